// File: rtl/dmrfy_pkg.sv
// Shared types and constants for the dmrf_y load path.
package dmrfy_pkg;

    localparam int unsigned DMRFY_ADDR_W = 5;
    localparam int unsigned DMRFY_TILE_W = 8;

    // Must match the dmrf_y mode_sel encoding.
    localparam logic MODE_INT8 = 1'b0;
    localparam logic MODE_BF16 = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StDrain
    } state_e;

    typedef struct packed {
        logic                    mode;
        logic [DMRFY_ADDR_W-1:0] depth;
        logic [DMRFY_TILE_W-1:0] num_tiles;
        logic                    first_sel;
    } cmd_t;

endpackage

// File: rtl/axis_route_slot.sv
// Single-entry AXIS register slot carrying a destination bit; valid is demuxed to two ports.
module axis_route_slot #(
    parameter int unsigned Width = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] in_data_i,
    input  logic             in_dest_i,
    output logic [Width-1:0] out_data_o,
    output logic             out0_valid_o,
    input  logic             out0_ready_i,
    output logic             out1_valid_o,
    input  logic             out1_ready_i,
    output logic             out_hs_o
);

    logic             valid_q, valid_d;
    logic             dest_q;
    logic [Width-1:0] data_q;
    logic             load;

    always_comb begin
        out0_valid_o = valid_q & ~dest_q;
        out1_valid_o = valid_q & dest_q;
        out_hs_o     = (out0_valid_o & out0_ready_i) | (out1_valid_o & out1_ready_i);
        // Refill in the same cycle the held beat leaves, for full throughput.
        in_ready_o   = ~valid_q | out_hs_o;
        load         = in_valid_i & in_ready_o;
        valid_d      = valid_q;
        if (out_hs_o) valid_d = 1'b0;
        if (load)     valid_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) valid_q <= 1'b0;
        else        valid_q <= valid_d;
    end

    always_ff @(posedge clk) begin
        if (load) begin
            data_q <= in_data_i;
            dest_q <= in_dest_i;
        end
    end

    assign out_data_o = data_q;

endmodule

// File: rtl/dmrfy_load_dispatcher.sv
// Steers DMA beats to the two dmrf_y load ports per command: INT8 ping-pongs tiles, BF16 holds one
// destination. Accept-side counters route; done-side counters time the completion pulses.
module dmrfy_load_dispatcher
    import dmrfy_pkg::*;
#(
    parameter int unsigned AXIS_LOAD_DATA_WIDTH = 256,
    parameter int unsigned LOAD_ADDR_WIDTH      = DMRFY_ADDR_W,
    parameter int unsigned TILE_CNT_WIDTH       = DMRFY_TILE_W
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_mode,
    input  logic [LOAD_ADDR_WIDTH-1:0]      cmd_depth,
    input  logic [TILE_CNT_WIDTH-1:0]       cmd_num_tiles,
    input  logic                            cmd_first_sel,
    input  logic [AXIS_LOAD_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    output logic [AXIS_LOAD_DATA_WIDTH-1:0] m_axis_dmrfy0_tdata,
    output logic                            m_axis_dmrfy0_tvalid,
    input  logic                            m_axis_dmrfy0_tready,
    output logic [AXIS_LOAD_DATA_WIDTH-1:0] m_axis_dmrfy1_tdata,
    output logic                            m_axis_dmrfy1_tvalid,
    input  logic                            m_axis_dmrfy1_tready,
    output logic                            tile_done,
    output logic                            xfer_done,
    output logic                            tlast_err,
    output logic                            busy
);

    state_e                              state_q, state_d;
    cmd_t                                cmd_q, cmd_d;
    logic [LOAD_ADDR_WIDTH-1:0]          acc_beat_q, acc_beat_d, done_beat_q, done_beat_d;
    logic [TILE_CNT_WIDTH-1:0]           acc_tile_q, acc_tile_d, done_tile_q, done_tile_d;
    logic                                err_q, err_d;
    logic                                cmd_hs, in_valid, in_ready, accept, down_hs, cur_sel;
    logic                                acc_tile_end, acc_last, done_tile_end, done_last;
    logic [AXIS_LOAD_DATA_WIDTH-1:0]     slot_data;

    assign cmd_hs        = cmd_valid & cmd_ready;
    assign in_valid      = s_axis_tvalid & (state_q == StStream);
    assign accept        = in_valid & in_ready;
    assign acc_tile_end  = (acc_beat_q == cmd_q.depth);
    assign acc_last      = acc_tile_end & (acc_tile_q == cmd_q.num_tiles);
    assign done_tile_end = (done_beat_q == cmd_q.depth);
    assign done_last     = done_tile_end & (done_tile_q == cmd_q.num_tiles);
    // INT8 alternates BRAMs on odd tiles; BF16 stays on the commanded one.
    assign cur_sel = (cmd_q.mode == MODE_BF16) ? cmd_q.first_sel
                                               : cmd_q.first_sel ^ acc_tile_q[0];

    axis_route_slot #(
        .Width (AXIS_LOAD_DATA_WIDTH)
    ) u_slot (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_data_i    (s_axis_tdata),
        .in_dest_i    (cur_sel),
        .out_data_o   (slot_data),
        .out0_valid_o (m_axis_dmrfy0_tvalid),
        .out0_ready_i (m_axis_dmrfy0_tready),
        .out1_valid_o (m_axis_dmrfy1_tvalid),
        .out1_ready_i (m_axis_dmrfy1_tready),
        .out_hs_o     (down_hs)
    );

    assign m_axis_dmrfy0_tdata = slot_data;
    assign m_axis_dmrfy1_tdata = slot_data;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (cmd_hs)             state_d = StStream;
            StStream: if (accept && acc_last) state_d = StDrain;
            StDrain:  if (down_hs)            state_d = StIdle;
            default:                          state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd_ready     = (state_q == StIdle);
        s_axis_tready = (state_q == StStream) & in_ready;
        busy          = (state_q != StIdle);
        tile_done     = down_hs & done_tile_end;
        xfer_done     = down_hs & done_last;
        tlast_err     = err_q;
    end

    always_comb begin
        cmd_d       = cmd_q;
        acc_beat_d  = acc_beat_q;
        acc_tile_d  = acc_tile_q;
        done_beat_d = done_beat_q;
        done_tile_d = done_tile_q;
        err_d       = err_q;
        if (cmd_hs) begin
            cmd_d       = '{mode: cmd_mode, depth: cmd_depth, num_tiles: cmd_num_tiles,
                            first_sel: cmd_first_sel};
            acc_beat_d  = '0;
            acc_tile_d  = '0;
            done_beat_d = '0;
            done_tile_d = '0;
            err_d       = 1'b0;
        end else begin
            if (accept) begin
                if (s_axis_tlast != acc_last) err_d = 1'b1;
                if (acc_tile_end) begin
                    acc_beat_d = '0;
                    acc_tile_d = acc_tile_q + 1'b1;
                end else begin
                    acc_beat_d = acc_beat_q + 1'b1;
                end
            end
            if (down_hs) begin
                if (done_tile_end) begin
                    done_beat_d = '0;
                    done_tile_d = done_tile_q + 1'b1;
                end else begin
                    done_beat_d = done_beat_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_q       <= '0;
            acc_beat_q  <= '0;
            acc_tile_q  <= '0;
            done_beat_q <= '0;
            done_tile_q <= '0;
            err_q       <= 1'b0;
        end else begin
            cmd_q       <= cmd_d;
            acc_beat_q  <= acc_beat_d;
            acc_tile_q  <= acc_tile_d;
            done_beat_q <= done_beat_d;
            done_tile_q <= done_tile_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_dmrfy_load_dispatcher.sv
// Bench for dmrfy_load_dispatcher: table of transfers, randomized transfers, reset and
// back-to-back command sequences, all checked beat-by-beat against a transfer-level model.
module tb_dmrfy_load_dispatcher;

    localparam int DW = 256;
    localparam int AW = 5;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_mode, cmd_first_sel;
    logic [AW-1:0] cmd_depth;
    logic [TW-1:0] cmd_num_tiles;
    logic [DW-1:0] s_tdata, d0_tdata, d1_tdata;
    logic          s_tvalid, s_tready, s_tlast;
    logic          d0_tvalid, d0_tready, d1_tvalid, d1_tready;
    logic          tile_done, xfer_done, tlast_err, busy;

    always #5 clk = ~clk;

    dmrfy_load_dispatcher dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .cmd_valid            (cmd_valid),
        .cmd_ready            (cmd_ready),
        .cmd_mode             (cmd_mode),
        .cmd_depth            (cmd_depth),
        .cmd_num_tiles        (cmd_num_tiles),
        .cmd_first_sel        (cmd_first_sel),
        .s_axis_tdata         (s_tdata),
        .s_axis_tvalid        (s_tvalid),
        .s_axis_tready        (s_tready),
        .s_axis_tlast         (s_tlast),
        .m_axis_dmrfy0_tdata  (d0_tdata),
        .m_axis_dmrfy0_tvalid (d0_tvalid),
        .m_axis_dmrfy0_tready (d0_tready),
        .m_axis_dmrfy1_tdata  (d1_tdata),
        .m_axis_dmrfy1_tvalid (d1_tvalid),
        .m_axis_dmrfy1_tready (d1_tready),
        .tile_done            (tile_done),
        .xfer_done            (xfer_done),
        .tlast_err            (tlast_err),
        .busy                 (busy)
    );

    typedef struct {
        logic mode;
        int   depth;
        int   ntiles;
        logic first;
        int   bad_pos;    // beat index carrying a spurious tlast, -1 for none
        bit   drop_last;  // omit tlast on the final beat
        int   rdy_pat;    // 0: always ready, 1: dmrfy1 toggles, 2: random
        bit   gaps;       // random DMA valid gaps
        bit   hold_next;  // keep cmd_valid high with the next command through the transfer
        int   exp0;       // -1 skips the per-port/tile totals
        int   exp1;
        int   exp_tiles;
        int   exp_err;    // -1 uses the model's framing verdict
    } vec_t;

    vec_t vecs[9];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand256();
        logic [DW-1:0] r = '0;
        for (int i = 0; i < DW / 32; i++) r = {r[DW-33:0], 32'($urandom())};
        return r;
    endfunction

    task automatic drive_cmd(input vec_t v);
        cmd_mode      = v.mode;
        cmd_depth     = v.depth[AW-1:0];
        cmd_num_tiles = v.ntiles[TW-1:0];
        cmd_first_sel = v.first;
    endtask

    task automatic run_xfer(input vec_t v, input bit pre_issued, input vec_t nxt);
        int            total = (v.depth + 1) * (v.ntiles + 1);
        logic [DW-1:0] sent[$];
        logic [DW-1:0] cur_data = '0;
        logic [DW-1:0] stall_data = '0;
        int            k_sent = 0, k_recv = 0, c0 = 0, c1 = 0, tiles = 0, cyc = 0, tile;
        bit            err_exp = 0, pend = 0, stall = 0, stall_dest = 0, done = 0;
        bit            hs0, hs1, exp_dest;
        if (!pre_issued) begin
            @(negedge clk);
            cmd_valid = 1'b1;
            drive_cmd(v);
            #1;
            chk("cmd_ready_idle", cmd_ready, 1);
        end
        while (!done && cyc < 4000) begin
            @(negedge clk);
            cmd_valid = v.hold_next;
            if (v.hold_next) drive_cmd(nxt);
            if (!pend) begin
                pend = v.gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (pend) cur_data = rand256();
            end
            s_tvalid = pend;
            s_tdata  = cur_data;
            s_tlast  = (k_sent == v.bad_pos) || (k_sent == total - 1 && !v.drop_last);
            case (v.rdy_pat)
                0: begin d0_tready = 1'b1; d1_tready = 1'b1; end
                1: begin d0_tready = 1'b1; d1_tready = ~cyc[0]; end
                default: begin
                    d0_tready = 1'($urandom_range(0, 1));
                    d1_tready = 1'($urandom_range(0, 1));
                end
            endcase
            #1;
            chk("busy", busy, 1);
            chk("cmd_ready_busy", cmd_ready, 0);
            chk("tlast_err", tlast_err, err_exp);
            chk("dual_valid", d0_tvalid & d1_tvalid, 0);
            if (stall) begin
                chk("stall_valid", stall_dest ? d1_tvalid : d0_tvalid, 1);
                chk("stall_data", stall_dest ? d1_tdata : d0_tdata, stall_data);
            end
            hs0 = d0_tvalid & d0_tready;
            hs1 = d1_tvalid & d1_tready;
            if (hs0 | hs1) begin
                chk("out_in_range", k_recv < total, 1);
                if (k_recv < total) begin
                    tile     = k_recv / (v.depth + 1);
                    exp_dest = v.mode ? v.first : v.first ^ tile[0];
                    chk("dest", hs1, exp_dest);
                    chk("data", hs1 ? d1_tdata : d0_tdata, sent[k_recv]);
                    chk("tile_done", tile_done, (k_recv % (v.depth + 1)) == v.depth);
                    chk("xfer_done", xfer_done, k_recv == total - 1);
                    if (k_recv == total - 1 && v.rdy_pat == 0 && !v.gaps)
                        chk("throughput", cyc, total);
                end
                k_recv++;
                c0    += int'(hs0);
                c1    += int'(hs1);
                tiles += int'(tile_done);
                if (xfer_done) done = 1'b1;
            end else begin
                chk("tile_done_idle", tile_done, 0);
                chk("xfer_done_idle", xfer_done, 0);
            end
            stall = (d0_tvalid | d1_tvalid) & ~(hs0 | hs1);
            if (stall) begin
                stall_dest = d1_tvalid;
                stall_data = d1_tvalid ? d1_tdata : d0_tdata;
                chk("tready_stall", s_tready, 0);
            end
            if (s_tvalid & s_tready) begin
                chk("in_in_range", k_sent < total, 1);
                if (k_sent < total) begin
                    sent.push_back(cur_data);
                    if (s_tlast != (k_sent == total - 1)) err_exp = 1'b1;
                end
                k_sent++;
                pend = 1'b0;
            end
            cyc++;
        end
        chk("xfer_seen", done, 1);
        @(negedge clk);
        s_tvalid  = 1'b0;
        s_tlast   = 1'b0;
        cmd_valid = v.hold_next;
        #1;
        chk("end_busy", busy, 0);
        chk("end_cmd_ready", cmd_ready, 1);
        chk("end_valid0", d0_tvalid, 0);
        chk("end_valid1", d1_tvalid, 0);
        chk("end_tready", s_tready, 0);
        chk("end_tlast_err", tlast_err, (v.exp_err >= 0) ? 1'(v.exp_err) : err_exp);
        if (v.exp0 >= 0) begin
            chk("count_dmrfy0", c0, v.exp0);
            chk("count_dmrfy1", c1, v.exp1);
            chk("count_tiles", tiles, v.exp_tiles);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v, none;
        int   n, guard, total;
        none = '{0, 0, 0, 0, -1, 0, 0, 0, 0, -1, -1, -1, -1};

        vecs[0] = '{0, 3,  1, 1'b0, -1, 0, 0, 0, 0,  4,  4, 2, 0};
        vecs[1] = '{1, 0,  2, 1'b1, -1, 0, 0, 0, 0,  0,  3, 3, 0};
        vecs[2] = '{0, 3,  1, 1'b0, -1, 0, 1, 0, 0,  4,  4, 2, 0};
        vecs[3] = '{0, 3,  1, 1'b1,  2, 0, 0, 0, 0,  4,  4, 2, 1};
        vecs[4] = '{1, 1,  1, 1'b0, -1, 1, 2, 1, 0,  4,  0, 2, 1};
        vecs[5] = '{0, 0,  3, 1'b1, -1, 0, 0, 0, 1,  2,  2, 4, 0};
        vecs[6] = '{1, 2,  0, 1'b1, -1, 0, 0, 0, 0,  0,  3, 1, 0};
        vecs[7] = '{0, 7,  2, 1'b0, -1, 0, 2, 1, 0, 16,  8, 3, 0};
        vecs[8] = '{0, 31, 0, 1'b1, -1, 0, 0, 0, 0,  0, 32, 1, 0};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        drive_cmd(none);
        s_tvalid  = 1'b0;
        s_tlast   = 1'b0;
        s_tdata   = '0;
        d0_tready = 1'b1;
        d1_tready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_tready", s_tready, 0);
        chk("rst_valid0", d0_tvalid, 0);
        chk("rst_valid1", d1_tvalid, 0);
        chk("rst_tile_done", tile_done, 0);
        chk("rst_xfer_done", xfer_done, 0);
        chk("rst_tlast_err", tlast_err, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_xfer(vecs[i], (i > 0) && vecs[i-1].hold_next, (i < 8) ? vecs[i+1] : none);
        end

        for (int i = 0; i < 25; i++) begin
            v        = none;
            v.mode   = 1'($urandom_range(0, 1));
            v.depth  = $urandom_range(0, 7);
            v.ntiles = $urandom_range(0, 3);
            v.first  = 1'($urandom_range(0, 1));
            total    = (v.depth + 1) * (v.ntiles + 1);
            if (total > 1 && $urandom_range(0, 3) == 0) v.bad_pos = $urandom_range(0, total - 2);
            v.drop_last = ($urandom_range(0, 5) == 0);
            v.rdy_pat   = $urandom_range(0, 2);
            v.gaps      = 1'($urandom_range(0, 1));
            run_xfer(v, 1'b0, none);
        end

        // Reset right after beat 5 of an 8-beat INT8 transfer is accepted.
        @(negedge clk);
        cmd_valid = 1'b1;
        v         = '{0, 3, 1, 1'b1, -1, 0, 0, 0, 0, -1, -1, -1, -1};
        drive_cmd(v);
        d0_tready = 1'b1;
        d1_tready = 1'b1;
        #1;
        chk("rst_seq_cmd_ready", cmd_ready, 1);
        n     = 0;
        guard = 0;
        while (n < 6 && guard < 50) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            s_tvalid  = 1'b1;
            s_tlast   = 1'b0;
            s_tdata   = rand256();
            #1;
            if (s_tvalid & s_tready) n++;
            guard++;
        end
        chk("rst_seq_accepts", n, 6);
        @(negedge clk);
        rst_n    = 1'b0;
        s_tvalid = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst_cmd_ready", cmd_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_valid0", d0_tvalid, 0);
        chk("midrst_valid1", d1_tvalid, 0);
        chk("midrst_tile_done", tile_done, 0);
        chk("midrst_xfer_done", xfer_done, 0);
        chk("midrst_tready", s_tready, 0);
        rst_n = 1'b1;
        v     = '{0, 1, 1, 1'b0, -1, 0, 0, 0, 0, 2, 2, 2, 0};
        run_xfer(v, 1'b0, none);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/dmrfy_load_dispatcher.md
Name: dmrfy_load_dispatcher

Overview:
Upstream feeder for the Y-operand double-buffered register file. It takes one 256-bit AXIS stream from the DMA and steers each beat to the dmrfy0 or dmrfy1 load port, following a per-transfer command. INT8 mode fills whole tiles and ping-pongs between the two BRAMs. BF16 mode steers single vectors to the BRAM selected by the command. It counts beats, checks framing, and reports completion to the controller.

Parameters:
AXIS_LOAD_DATA_WIDTH, 256, beat width on all stream ports
LOAD_ADDR_WIDTH, 5, width of depth field (tile = depth+1 beats)
TILE_CNT_WIDTH, 8, width of tile-count field (tiles = num_tiles+1)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_mode  in  1  0=INT8 tile ping-pong, 1=BF16 per-command select
cmd_depth  in  LOAD_ADDR_WIDTH  beats per tile minus 1
cmd_num_tiles  in  TILE_CNT_WIDTH  tiles in transfer minus 1
cmd_first_sel  in  1  destination of first tile (0=dmrfy0, 1=dmrfy1)
s_axis_tdata  in  AXIS_LOAD_DATA_WIDTH  DMA beat
s_axis_tvalid  in  1  DMA beat valid
s_axis_tready  out  1  DMA beat accept
s_axis_tlast  in  1  marks final beat of transfer
m_axis_dmrfy0_tdata  out  AXIS_LOAD_DATA_WIDTH  beat to BRAM0 load port
m_axis_dmrfy0_tvalid  out  1  valid to BRAM0
m_axis_dmrfy0_tready  in  1  ready from BRAM0
m_axis_dmrfy1_tdata  out  AXIS_LOAD_DATA_WIDTH  beat to BRAM1 load port
m_axis_dmrfy1_tvalid  out  1  valid to BRAM1
m_axis_dmrfy1_tready  in  1  ready from BRAM1
tile_done  out  1  one-cycle pulse when the last beat of a tile is accepted downstream
xfer_done  out  1  one-cycle pulse when the last beat of the transfer is accepted downstream
tlast_err  out  1  sticky framing error, cleared by next accepted command
busy  out  1  high from command accept until xfer_done

Behaviour:
- Reset: state IDLE. cmd_ready=1, s_axis_tready=0, both m_tvalid=0, tile_done=0, xfer_done=0, tlast_err=0, busy=0. Data registers are don't-care.
- Reset is synchronous and wins over everything. Reset mid-transfer drops the in-flight beat and returns to IDLE; no done pulse is emitted.
- FSM states:
  - IDLE: on cmd handshake, latch mode, depth, num_tiles and first_sel. Set cur_sel=first_sel, beat_cnt=0, tile_cnt=0, clear tlast_err, go to STREAM. cmd_ready=1 only in IDLE.
  - STREAM: accept beats and route them to cur_sel.
  - DRAIN: the last beat has been accepted from the DMA and waits in the output register. On its downstream handshake, go to IDLE.
- Output stage is a single registered slot, giving 1-cycle latency from the s_axis handshake to m_tvalid.
  - s_axis_tready = (state==STREAM) & (slot empty | selected-port handshake this cycle). This gives full throughput with downstream ready held high.
  - The slot holds data and a dest bit. m_axis_dmrfyN_tvalid = slot_valid & (dest==N). The tdata of both ports is driven from the slot.
  - Data and valid stay stable while tready is low.
- Counting is done on the downstream handshake of the slot beat, so the done pulses align with the dmrf_y write:
  - beat_cnt==depth: beat_cnt<=0, tile_done pulse, tile_cnt++.
  - INT8 mode: cur_sel toggles at each tile boundary.
  - BF16 mode: cur_sel is held for the whole transfer.
  - Last beat of the transfer = (beat_cnt==depth) & (tile_cnt==num_tiles). On it, xfer_done pulses in the same cycle as tile_done.
- Routing (cur_sel for the next incoming beat) is computed from the accept-side counters. Accept-side counters are separate from the done-side counters, so a tile boundary with a beat still in the slot routes correctly.
- Framing:
  - tlast on a non-final beat sets tlast_err; the beat is still forwarded.
  - A final beat without tlast sets tlast_err; the transfer still completes by count.
  - Beats beyond the count are not accepted (s_axis_tready=0 outside STREAM).
- depth=0 → every beat is its own tile. num_tiles=0 → single tile.
- A new command is not accepted until xfer_done has been asserted and the FSM is back in IDLE. The handshake is accepted no earlier than the cycle after xfer_done.

Decomposition:
- Shared package dmrfy_pkg holds:
  - the state enum (IDLE/STREAM/DRAIN);
  - the mode constants MODE_INT8=0 and MODE_BF16=1, which must match the dmrf_y mode_sel encoding;
  - a packed cmd struct {mode, depth, num_tiles, first_sel}.
- One natural sub-module: axis_route_slot, the single-entry register slot with dest bit and two-way valid demux.

Test Plan:
1. INT8, depth=3, num_tiles=1, first_sel=0, downstream ready=1, continuous DMA → beats 0-3 on dmrfy0 and 4-7 on dmrfy1, one per cycle. tile_done on beats 3 and 7; xfer_done with beat 7. tlast_err=0.
2. BF16, depth=0, num_tiles=2, first_sel=1 → all 3 beats on dmrfy1. tile_done ×3, xfer_done on the 3rd. dmrfy0_tvalid never high.
3. Backpressure: test 1 with m_axis_dmrfy1_tready toggling 1/0 per cycle → data stable while stalled. No beat lost or duplicated; s_axis_tready low during stalls.
4. Framing: tlast on beat 2 of an 8-beat transfer → tlast_err=1 from the cycle after beat 2 is accepted. All 8 beats are delivered and xfer_done pulses. The next command handshake clears tlast_err.
5. Reset mid-transfer after beat 5 is accepted → the next cycle shows state IDLE, all valids 0, cmd_ready=1, and no done pulses. A new command then starts at first_sel.
6. Back-to-back commands: cmd_valid held high across a transfer end → the second command is accepted only in IDLE after xfer_done. Its first beat routes to its own first_sel.
